complex_multiplier_axis: RTL
============================

COMPLEX_MULTIPLIER_AXIS -- requirements
Module: complex_multiplier_axis

Interface
REQ-001 Parameter OPERAND_WIDTH_A, 16, bits per real/imag part of operand a (even, 4..27).
REQ-002 Parameter OPERAND_WIDTH_B, 16, bits per real/imag part of operand b (even, 4..27).
REQ-003 Parameter OPERAND_WIDTH_OUT, 16, bits per real/imag part of the result.
REQ-004 Parameter SHIFT, 15, right shift applied to the full-precision product (0..OPERAND_WIDTH_A+OPERAND_WIDTH_B).
REQ-005 Parameter LATENCY, 6, accepted beat to m_axis_dout_tvalid in cycles when not stalled (minimum 4).
REQ-006 Parameter ROUND_MODE, 0, 0 = floor truncation, 1 = round half up.
REQ-007 aclk  in  1  clock; all logic rising-edge.
REQ-008 aresetn  in  1  reset, asynchronous assert, active-low.
REQ-009 s_axis_a_tdata  in  ((2*OPERAND_WIDTH_A+15)/16)*16  real part in LSBs, imag part at half-width offset.
REQ-010 s_axis_a_tvalid / s_axis_a_tready / s_axis_a_tlast  in/out/in  1 each  operand a stream.
REQ-011 s_axis_b_tdata  in  ((2*OPERAND_WIDTH_B+15)/16)*16  same packing as a.
REQ-012 s_axis_b_tvalid / s_axis_b_tready  in/out  1 each  operand b stream.
REQ-013 conj_b  in  1  when 1, the beat computes a*conj(b); sampled with the accepted beat.
REQ-014 m_axis_dout_tdata  out  ((2*OPERAND_WIDTH_OUT+15)/16)*16  real part in the low half, imag part in the high half, each sign-extended to its half.
REQ-015 m_axis_dout_tvalid / m_axis_dout_tready / m_axis_dout_tlast  out/in/out  1 each  result stream.
REQ-016 m_axis_dout_tuser  out  1  overflow flag for this beat.

Function
REQ-017 The enable ce SHALL equal (~m_axis_dout_tvalid | m_axis_dout_tready); both s tready outputs SHALL equal ce and SHALL be 0 while aresetn is low.
REQ-018 A beat SHALL be accepted only when s_axis_a_tvalid, s_axis_b_tvalid and ce are all 1; a lone valid SHALL consume nothing.
REQ-019 When ce is 0, all pipeline registers (data, valid, tlast, conj) SHALL hold.
REQ-020 An accepted beat SHALL appear on m_axis_dout_* exactly LATENCY ce-cycles later; throughput is one beat per cycle while m_axis_dout_tready=1.
REQ-021 Full-precision product: p_r = a_r*b_r - s*a_i*b_i and p_i = a_i*b_r + s*a_r*b_i (signed, OPERAND_WIDTH_A+OPERAND_WIDTH_B+1 bits), with s=+1 normally and s=-1 for conj_b (b_i negated, carried to full width without overflow).
REQ-022 ROUND_MODE 1 SHALL add 2^(SHIFT-1) before an arithmetic right shift by SHIFT; ROUND_MODE 0 or SHIFT=0 SHALL shift only.
REQ-023 Narrowing to OPERAND_WIDTH_OUT SHALL follow REQ-034/035; m_axis_dout_tuser SHALL be 1 iff either part exceeded the output range.
REQ-024 m_axis_dout_tlast SHALL equal the s_axis_a_tlast of the same beat.
REQ-025 Output data SHALL remain stable while m_axis_dout_tvalid=1 and m_axis_dout_tready=0.

Reset
REQ-026 Asserting aresetn low SHALL immediately clear every pipeline valid bit, m_axis_dout_tvalid, m_axis_dout_tdata, m_axis_dout_tlast and m_axis_dout_tuser to 0.
REQ-027 In-flight beats SHALL be discarded on reset mid-operation; no result SHALL be emitted for them after release.
REQ-028 After deassertion, both s tready outputs SHALL be 1 in the first cycle.
REQ-029 Datapath registers other than the output may be left unreset.

Configuration
REQ-030 Macro CMULT_SATURATE_EN SHALL select the narrowing behaviour.
REQ-031 Defined: an out-of-range part SHALL clamp to +2^(OPERAND_WIDTH_OUT-1)-1 or -2^(OPERAND_WIDTH_OUT-1).
REQ-032 Undefined: an out-of-range part SHALL wrap (keep the low OPERAND_WIDTH_OUT bits).
REQ-033 m_axis_dout_tuser SHALL report overflow in both builds.
REQ-034 Range check SHALL be performed on the rounded, shifted value.
REQ-035 Build-time choice only; no runtime control.

Verification (OPERAND_WIDTH_A=B=16, OUT=16, SHIFT=0 unless stated)
REQ-036 a=(3,4), b=(1,2), conj_b=0 -> dout real=-5, imag=10, tuser=0, tvalid exactly 6 cycles after acceptance.
REQ-037 Same operands, conj_b=1 -> real=11, imag=-2.
REQ-038 SHIFT=15, a=b=(-32768,-32768) -> imag 2^16: 32767 with tuser=1 under CMULT_SATURATE_EN, 0 with tuser=1 without it; real=0.
REQ-039 SHIFT=1, ROUND_MODE=1, product real=3 -> 2; ROUND_MODE=0 -> 1; product real=-3 -> -1 and -2 respectively.
REQ-040 Stream 8 beats with tlast on beat 8 while m_axis_dout_tready toggles every cycle -> all 8 results in order, none lost or duplicated, tlast only on the 8th, s tready low exactly while the output is stalled.
REQ-041 a valid without b for 5 cycles, then b -> exactly one result; pulse aresetn low with 3 beats in flight -> no outputs after release, tready=1 on the next cycle.

Source files
------------

// File: rtl/complex_multiplier_axis.sv
`default_nettype none
// ============================================================================
// Module   : complex_multiplier_axis
// Purpose  : AXI-Stream complex multiplier (a*b or a*conj(b)) with rounding,
//            scaling and overflow flag. Build macro CMULT_SATURATE_EN selects
//            clamping instead of wrap-around on out-of-range results.
// Revision : 1.0 - initial release
// ============================================================================
module complex_multiplier_axis #(
   parameter int OPERAND_WIDTH_A   = 16,
   parameter int OPERAND_WIDTH_B   = 16,
   parameter int OPERAND_WIDTH_OUT = 16,
   parameter int SHIFT             = 15,
   parameter int LATENCY           = 6,
   parameter int ROUND_MODE        = 0
) (
   input  logic                                                  aclk,
   input  logic                                                  aresetn,
   input  logic [((2*OPERAND_WIDTH_A+15)/16)*16-1:0]              s_axis_a_tdata,
   input  logic                                                  s_axis_a_tvalid,
   output logic                                                  s_axis_a_tready,
   input  logic                                                  s_axis_a_tlast,
   input  logic [((2*OPERAND_WIDTH_B+15)/16)*16-1:0]              s_axis_b_tdata,
   input  logic                                                  s_axis_b_tvalid,
   output logic                                                  s_axis_b_tready,
   input  logic                                                  conj_b,
   output logic [((2*OPERAND_WIDTH_OUT+15)/16)*16-1:0]            m_axis_dout_tdata,
   output logic                                                  m_axis_dout_tvalid,
   input  logic                                                  m_axis_dout_tready,
   output logic                                                  m_axis_dout_tlast,
   output logic                                                  m_axis_dout_tuser
);

   localparam int c_dw_a   = ((2*OPERAND_WIDTH_A+15)/16)*16;
   localparam int c_half_a = c_dw_a / 2;
   localparam int c_dw_b   = ((2*OPERAND_WIDTH_B+15)/16)*16;
   localparam int c_half_b = c_dw_b / 2;
   localparam int c_dw_o   = ((2*OPERAND_WIDTH_OUT+15)/16)*16;
   localparam int c_half_o = c_dw_o / 2;
   // One guard bit above the full-precision width absorbs the rounding constant.
   localparam int c_pw     = OPERAND_WIDTH_A + OPERAND_WIDTH_B + 2;
   localparam int c_we     = (c_pw > OPERAND_WIDTH_OUT) ? c_pw : OPERAND_WIDTH_OUT + 1;
   localparam int c_rnd_sh = (SHIFT > 0) ? SHIFT - 1 : 0;
   localparam logic signed [c_pw-1:0] c_rnd =
      (ROUND_MODE == 1 && SHIFT > 0) ? (c_pw'(1) <<< c_rnd_sh) : '0;

   logic                               w_ce;
   logic                               w_accept;
   logic signed [OPERAND_WIDTH_B-1:0]  w_bi_in;
   logic signed [OPERAND_WIDTH_B:0]    w_bi_ext;
   logic signed [OPERAND_WIDTH_B:0]    w_bi_sel;

   logic signed [OPERAND_WIDTH_A-1:0]  r_s1_ar;
   logic signed [OPERAND_WIDTH_A-1:0]  r_s1_ai;
   logic signed [OPERAND_WIDTH_B-1:0]  r_s1_br;
   logic signed [OPERAND_WIDTH_B:0]    r_s1_bi;

   logic signed [c_pw-1:0]             r_s2_rr;
   logic signed [c_pw-1:0]             r_s2_ii;
   logic signed [c_pw-1:0]             r_s2_ir;
   logic signed [c_pw-1:0]             r_s2_ri;

   logic signed [c_pw-1:0]             w_re_sum;
   logic signed [c_pw-1:0]             w_im_sum;
   logic signed [c_pw-1:0]             w_re_sh;
   logic signed [c_pw-1:0]             w_im_sh;
   logic signed [c_pw-1:0]             r_s3_re;
   logic signed [c_pw-1:0]             r_s3_im;

   logic signed [c_pw-1:0]             w_pre_re;
   logic signed [c_pw-1:0]             w_pre_im;
   logic signed [c_we-1:0]             w_re_ext;
   logic signed [c_we-1:0]             w_im_ext;
   logic signed [OPERAND_WIDTH_OUT-1:0] w_re_n;
   logic signed [OPERAND_WIDTH_OUT-1:0] w_im_n;
   logic                               w_re_ovf;
   logic                               w_im_ovf;
   logic signed [c_half_o-1:0]         w_re_x;
   logic signed [c_half_o-1:0]         w_im_x;

   logic [LATENCY-2:0]                 r_vld;
   logic [LATENCY-2:0]                 r_last;
   logic                               r_tvalid;
   logic [c_dw_o-1:0]                  r_tdata;
   logic                               r_tlast;
   logic                               r_tuser;

   assign w_ce            = ~r_tvalid | m_axis_dout_tready;
   assign w_accept        = s_axis_a_tvalid & s_axis_b_tvalid & w_ce;
   assign s_axis_a_tready = w_ce & aresetn;
   assign s_axis_b_tready = w_ce & aresetn;

   // b_i is widened before negation so that conj of the most negative value is exact.
   assign w_bi_in  = s_axis_b_tdata[c_half_b +: OPERAND_WIDTH_B];
   assign w_bi_ext = {w_bi_in[OPERAND_WIDTH_B-1], w_bi_in};
   assign w_bi_sel = conj_b ? -w_bi_ext : w_bi_ext;

   assign w_re_sum = r_s2_rr - r_s2_ii;
   assign w_im_sum = r_s2_ir + r_s2_ri;
   assign w_re_sh  = (w_re_sum + c_rnd) >>> SHIFT;
   assign w_im_sh  = (w_im_sum + c_rnd) >>> SHIFT;

   always_ff @(posedge aclk) begin
      if (w_ce) begin
         r_s1_ar <= s_axis_a_tdata[OPERAND_WIDTH_A-1:0];
         r_s1_ai <= s_axis_a_tdata[c_half_a +: OPERAND_WIDTH_A];
         r_s1_br <= s_axis_b_tdata[OPERAND_WIDTH_B-1:0];
         r_s1_bi <= w_bi_sel;
         r_s2_rr <= c_pw'(r_s1_ar) * c_pw'(r_s1_br);
         r_s2_ii <= c_pw'(r_s1_ai) * c_pw'(r_s1_bi);
         r_s2_ir <= c_pw'(r_s1_ai) * c_pw'(r_s1_br);
         r_s2_ri <= c_pw'(r_s1_ar) * c_pw'(r_s1_bi);
         r_s3_re <= w_re_sh;
         r_s3_im <= w_im_sh;
         r_last  <= {r_last[LATENCY-3:0], s_axis_a_tlast};
      end
   end

   generate
      if (LATENCY > 4) begin : g_dly
         logic signed [c_pw-1:0] r_dly_re [LATENCY-4];
         logic signed [c_pw-1:0] r_dly_im [LATENCY-4];
         always_ff @(posedge aclk) begin
            if (w_ce) begin
               r_dly_re[0] <= r_s3_re;
               r_dly_im[0] <= r_s3_im;
               for (int k = 1; k < LATENCY - 4; k++) begin
                  r_dly_re[k] <= r_dly_re[k-1];
                  r_dly_im[k] <= r_dly_im[k-1];
               end
            end
         end
         assign w_pre_re = r_dly_re[LATENCY-5];
         assign w_pre_im = r_dly_im[LATENCY-5];
      end else begin : g_nodly
         assign w_pre_re = r_s3_re;
         assign w_pre_im = r_s3_im;
      end
   endgenerate

   // Value fits iff every bit from the output sign bit upward agrees.
   function automatic logic [OPERAND_WIDTH_OUT:0] f_narrow(input logic signed [c_we-1:0] v);
      logic [c_we-OPERAND_WIDTH_OUT:0] top;
      logic                            ovf;
      logic [OPERAND_WIDTH_OUT-1:0]    res;
      top = v[c_we-1:OPERAND_WIDTH_OUT-1];
      ovf = ~((&top) | ~(|top));
      res = v[OPERAND_WIDTH_OUT-1:0];
`ifdef CMULT_SATURATE_EN
      if (ovf) begin
         res = v[c_we-1] ? {1'b1, {(OPERAND_WIDTH_OUT-1){1'b0}}}
                         : {1'b0, {(OPERAND_WIDTH_OUT-1){1'b1}}};
      end
`endif
      return {ovf, res};
   endfunction

   assign w_re_ext             = c_we'(w_pre_re);
   assign w_im_ext             = c_we'(w_pre_im);
   assign {w_re_ovf, w_re_n}   = f_narrow(w_re_ext);
   assign {w_im_ovf, w_im_n}   = f_narrow(w_im_ext);
   assign w_re_x               = c_half_o'(w_re_n);
   assign w_im_x               = c_half_o'(w_im_n);

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_vld    <= '0;
         r_tvalid <= 1'b0;
         r_tdata  <= '0;
         r_tlast  <= 1'b0;
         r_tuser  <= 1'b0;
      end else if (w_ce) begin
         r_vld    <= {r_vld[LATENCY-3:0], w_accept};
         r_tvalid <= r_vld[LATENCY-2];
         r_tdata  <= {w_im_x, w_re_x};
         r_tlast  <= r_last[LATENCY-2];
         r_tuser  <= w_re_ovf | w_im_ovf;
      end
   end

   assign m_axis_dout_tvalid = r_tvalid;
   assign m_axis_dout_tdata  = r_tdata;
   assign m_axis_dout_tlast  = r_tlast;
   assign m_axis_dout_tuser  = r_tuser;

endmodule
`default_nettype wire
